rtc_ad_bus_reader: RTL and testbench
====================================

Name: rtc_ad_bus_reader

Overview:
Read sequencer for the RTC's multiplexed address/data (AD) bus. It is the read-side counterpart of the date/time setting counters, which produce values to be written into the RTC. On a start pulse it drives a register address, then turns the bus around, strobes a read, and captures the returned byte. The captured byte is flagged as valid BCD and as a valid day-of-week code (1..7). It sits between the top-level bidirectional AD pad buffer and the display/control FSM.

Parameters:
T_SU, 2, setup/turnaround cycles before each strobe (1..255)
T_PW, 8, strobe (cs_n/wr_n or cs_n/rd_n low) width in cycles (1..255)
T_HD, 2, hold cycles after each strobe (1..255)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
start  in  1  request a register read; sampled only in IDLE
addr  in  8  RTC register address; latched when start is accepted
ad_in  in  8  AD bus value from the pad buffer
ad_out  out  8  value driven onto the AD bus while ad_oe=1
ad_oe  out  1  pad buffer output enable
cs_n  out  1  RTC chip select, active low
rd_n  out  1  RTC read strobe, active low
wr_n  out  1  RTC write strobe, active low
a_d  out  1  0 = address phase, 1 = data phase
busy  out  1  high in every state except IDLE
data_out  out  8  captured register byte
data_valid  out  1  one-cycle pulse when data_out is updated
bcd_ok  out  1  both nibbles of data_out are <= 9
day_ok  out  1  data_out is in 1..7

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values: cs_n=1, rd_n=1, wr_n=1, a_d=1, ad_oe=0, ad_out=0, busy=0, data_out=0, data_valid=0, bcd_ok=0, day_ok=0. State is IDLE.
- Reset mid-operation: the next edge forces the reset values. Any partial transaction is abandoned and data_out is cleared.
- FSM states, each with its own dwell time:
  - IDLE: bus at idle levels.
  - ADDR_SU (T_SU cycles): a_d=0, ad_oe=1, ad_out=latched addr.
  - ADDR_WR (T_PW cycles): ADDR_SU signals plus cs_n=0, wr_n=0.
  - ADDR_HD (T_HD cycles): cs_n=1, wr_n=1, address still driven.
  - TURN (T_SU cycles): ad_oe=0, a_d=1.
  - DATA_RD (T_PW cycles): cs_n=0, rd_n=0. ad_in is sampled into data_out on the last cycle.
  - DATA_HD (T_HD cycles): cs_n=1, rd_n=1.
  - DONE (1 cycle): data_valid=1, busy=1. Then back to IDLE.
- Latency: if start is sampled high in IDLE at edge k, DONE occupies the cycle after edge k+1+2*(T_SU+T_PW+T_HD). With defaults, data_valid is high after edge k+25.
- bcd_ok and day_ok are registered on the same edge as data_out and hold until the next capture or reset.
- Dwell counter: 8 bits, loaded with (dwell-1) on state entry. The state advances when the counter is 0.
- start is ignored while busy=1, including DONE. If start is held high continuously, the next transaction is accepted in the first IDLE cycle.
- Bus-safety invariants:
  - ad_oe=1 only in ADDR_SU, ADDR_WR and ADDR_HD.
  - rd_n and wr_n are never low in the same cycle.
  - rd_n=0 never coincides with ad_oe=1.

Decomposition:
- Shared package: state encoding, idle bus levels, default T_SU/T_PW/T_HD, and the day-range constants DAY_MIN=1 and DAY_MAX=7.
- One natural sub-module, ad_bus_timer: a loadable 8-bit down-counter with a zero flag, instantiated once and reloaded on every state entry.

Test Plan:
1. Assert reset for 3 cycles, with start=1 during reset -> every output at its reset value and no transaction begins.
2. start=1 for 1 cycle, addr=0x26, ad_in=0x05 -> a_d=0 with ad_out=0x26 and a cs_n/wr_n low pulse of 8 cycles, then a cs_n/rd_n low pulse of 8 cycles. At edge k+25: data_out=0x05, data_valid=1 for exactly 1 cycle, bcd_ok=1, day_ok=1.
3. ad_in=0x1A on a read -> data_out=0x1A, bcd_ok=0, day_ok=0. ad_in=0x00 on a read -> bcd_ok=1, day_ok=0.
4. Pulse start with addr=0x30 during ADDR_WR of a read to 0x26 -> ignored. Only one data_valid pulse, and the address driven stays 0x26.
5. Assert reset during DATA_RD -> next cycle cs_n=1, rd_n=1, busy=0, data_out=0, and no data_valid pulse.
6. Hold start high for 60 cycles -> two transactions, DONE at k+25 and k+51. Every cycle satisfies the bus-safety invariants.

Source files
------------

// File: rtl/rtc_ad_bus_reader_pkg.sv
// Shared types and constants for the RTC AD-bus read sequencer.
// Holds the state encoding, idle bus levels, default dwell times and byte classifiers.
package rtc_ad_bus_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_SU = 3'd1,
        ST_ADDR_WR = 3'd2,
        ST_ADDR_HD = 3'd3,
        ST_TURN    = 3'd4,
        ST_DATA_RD = 3'd5,
        ST_DATA_HD = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam int T_SU_DEF = 2;
    localparam int T_PW_DEF = 8;
    localparam int T_HD_DEF = 2;

    localparam logic IDLE_CS_N  = 1'b1;
    localparam logic IDLE_RD_N  = 1'b1;
    localparam logic IDLE_WR_N  = 1'b1;
    localparam logic IDLE_A_D   = 1'b1;
    localparam logic IDLE_AD_OE = 1'b0;

    localparam logic [7:0] DAY_MIN = 8'd1;
    localparam logic [7:0] DAY_MAX = 8'd7;

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic is_day(input logic [7:0] v);
        return (v >= DAY_MIN) && (v <= DAY_MAX);
    endfunction

endpackage

// File: rtl/ad_bus_timer.sv
// Loadable 8-bit down-counter with zero flag; saturates at zero.
// Load takes effect on the next edge; counts down by one per cycle otherwise.
module ad_bus_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_ad_bus_reader.sv
// Reads one RTC register over the multiplexed AD bus: address write, turnaround, read strobe, capture.
// Bus pins are registered from the state, so they trail the state register by one cycle; start is only accepted in IDLE.
module rtc_ad_bus_reader
    import rtc_ad_bus_reader_pkg::*;
#(
    parameter int T_SU = T_SU_DEF,
    parameter int T_PW = T_PW_DEF,
    parameter int T_HD = T_HD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       bcd_ok,
    output logic       day_ok
);

    localparam logic [7:0] SU_M1 = 8'(T_SU - 1);
    localparam logic [7:0] PW_M1 = 8'(T_PW - 1);
    localparam logic [7:0] HD_M1 = 8'(T_HD - 1);

    state_t     state_q, state_nxt;
    logic       tmr_load, tmr_zero;
    logic [7:0] tmr_val;
    logic [7:0] addr_q, cap_q;

    logic       cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d, busy_d;
    logic [7:0] ad_out_d;

    ad_bus_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            cap_q   <= 8'd0;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_IDLE && start) begin
                addr_q <= addr;
            end
            // Sample while the strobe is still asserted on the pins.
            if (state_q == ST_DATA_RD && tmr_zero) begin
                cap_q <= ad_in;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        tmr_load  = 1'b0;
        tmr_val   = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ADDR_SU;
                    tmr_load  = 1'b1;
                    tmr_val   = SU_M1;
                end
            end
            ST_ADDR_SU: if (tmr_zero) begin
                state_nxt = ST_ADDR_WR; tmr_load = 1'b1; tmr_val = PW_M1;
            end
            ST_ADDR_WR: if (tmr_zero) begin
                state_nxt = ST_ADDR_HD; tmr_load = 1'b1; tmr_val = HD_M1;
            end
            ST_ADDR_HD: if (tmr_zero) begin
                state_nxt = ST_TURN; tmr_load = 1'b1; tmr_val = SU_M1;
            end
            ST_TURN: if (tmr_zero) begin
                state_nxt = ST_DATA_RD; tmr_load = 1'b1; tmr_val = PW_M1;
            end
            ST_DATA_RD: if (tmr_zero) begin
                state_nxt = ST_DATA_HD; tmr_load = 1'b1; tmr_val = HD_M1;
            end
            ST_DATA_HD: if (tmr_zero) begin
                state_nxt = ST_DONE; tmr_load = 1'b1; tmr_val = 8'd0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n_d   = IDLE_CS_N;
        rd_n_d   = IDLE_RD_N;
        wr_n_d   = IDLE_WR_N;
        a_d_d    = IDLE_A_D;
        ad_oe_d  = IDLE_AD_OE;
        ad_out_d = 8'd0;
        busy_d   = (state_q != ST_IDLE);
        case (state_q)
            ST_ADDR_SU, ST_ADDR_HD: begin
                a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = addr_q;
            end
            ST_ADDR_WR: begin
                a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = addr_q;
                cs_n_d = 1'b0; wr_n_d = 1'b0;
            end
            ST_DATA_RD: begin
                cs_n_d = 1'b0; rd_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            a_d        <= 1'b1;
            ad_oe      <= 1'b0;
            ad_out     <= 8'd0;
            busy       <= 1'b0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            bcd_ok     <= 1'b0;
            day_ok     <= 1'b0;
        end else begin
            cs_n       <= cs_n_d;
            rd_n       <= rd_n_d;
            wr_n       <= wr_n_d;
            a_d        <= a_d_d;
            ad_oe      <= ad_oe_d;
            ad_out     <= ad_out_d;
            busy       <= busy_d;
            data_valid <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                data_out <= cap_q;
                bcd_ok   <= is_bcd(cap_q);
                day_ok   <= is_day(cap_q);
            end
        end
    end

endmodule

// File: tb/tb_rtc_ad_bus_reader.sv
// Directed, table-driven bench for the RTC AD-bus read sequencer.
module tb_rtc_ad_bus_reader;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] addr, ad_in;
    logic [7:0] ad_out, data_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, data_valid, bcd_ok, day_ok;

    int tests = 0;
    int failed = 0;

    // per-transaction observations, indexed from the edge that accepted start
    int dv_cnt, dv_first, dv_second, wr_cnt, wr_first, rd_cnt, rd_first, inv_bad, ad_bad;
    logic [7:0] dat_at_dv;
    logic       bcd_at_dv, day_at_dv;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_data;
        logic       exp_bcd;
        logic       exp_day;
    } vec_t;

    vec_t vecs[9];

    rtc_ad_bus_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (addr),
        .ad_in      (ad_in),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .a_d        (a_d),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bcd_ok     (bcd_ok),
        .day_ok     (day_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge. Starts a read, then samples every cycle for ncyc cycles.
    // start stays high while n+1 < hold; a one-cycle start with inj_addr is pulsed at n+1 == inj.
    task automatic run_monitor(input logic [7:0] a, input logic [7:0] d, input int ncyc,
                               input int hold, input int inj, input logic [7:0] inj_addr);
        dv_cnt = 0; dv_first = -1; dv_second = -1; wr_cnt = 0; wr_first = -1;
        rd_cnt = 0; rd_first = -1; inv_bad = 0; ad_bad = 0;
        dat_at_dv = 8'hxx; bcd_at_dv = 1'bx; day_at_dv = 1'bx;
        start = 1'b1; addr = a; ad_in = d;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            #1;
            start = (n + 1 < hold) || (n + 1 == inj);
            addr  = (n + 1 == inj) ? inj_addr : a;
            @(negedge clk);
            if ((ad_oe && a_d) || (!rd_n && !wr_n) || (!rd_n && ad_oe)) inv_bad++;
            if (!wr_n) begin
                if (wr_first < 0) wr_first = n;
                wr_cnt++;
                if (ad_out !== a || a_d !== 1'b0 || cs_n !== 1'b0) ad_bad++;
            end
            if (!rd_n) begin
                if (rd_first < 0) rd_first = n;
                rd_cnt++;
            end
            if (data_valid) begin
                dv_cnt++;
                if (dv_first < 0) begin
                    dv_first = n; dat_at_dv = data_out; bcd_at_dv = bcd_ok; day_at_dv = day_ok;
                end else if (dv_second < 0) begin
                    dv_second = n;
                end
            end
        end
        start = 1'b0;
        addr  = a;
    endtask

    initial begin
        vecs[0] = '{8'h26, 8'h05, 8'h05, 1'b1, 1'b1};
        vecs[1] = '{8'h27, 8'h1A, 8'h1A, 1'b0, 1'b0};
        vecs[2] = '{8'h28, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h29, 8'h07, 8'h07, 1'b1, 1'b1};
        vecs[4] = '{8'h2A, 8'h08, 8'h08, 1'b1, 1'b0};
        vecs[5] = '{8'h2B, 8'h99, 8'h99, 1'b1, 1'b0};
        vecs[6] = '{8'h2C, 8'h9A, 8'h9A, 1'b0, 1'b0};
        vecs[7] = '{8'h2D, 8'hA0, 8'hA0, 1'b0, 1'b0};
        vecs[8] = '{8'h2E, 8'h01, 8'h01, 1'b1, 1'b1};

        // reset held 3 cycles with start asserted
        reset = 1'b1; start = 1'b1; addr = 8'h55; ad_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_a_d", a_d, 1);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_ad_out", ad_out, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_bcd_ok", bcd_ok, 0);
        check("rst_day_ok", day_ok, 0);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cs_n", cs_n, 1);

        // table of single reads
        foreach (vecs[i]) begin
            run_monitor(vecs[i].a, vecs[i].d, 30, 1, -1, 8'h00);
            check($sformatf("v%0d_dv_cycle", i), dv_first, 25);
            check($sformatf("v%0d_dv_count", i), dv_cnt, 1);
            check($sformatf("v%0d_data", i), dat_at_dv, vecs[i].exp_data);
            check($sformatf("v%0d_bcd", i), bcd_at_dv, vecs[i].exp_bcd);
            check($sformatf("v%0d_day", i), day_at_dv, vecs[i].exp_day);
            check($sformatf("v%0d_wr_first", i), wr_first, 3);
            check($sformatf("v%0d_wr_width", i), wr_cnt, 8);
            check($sformatf("v%0d_rd_first", i), rd_first, 15);
            check($sformatf("v%0d_rd_width", i), rd_cnt, 8);
            check($sformatf("v%0d_addr_phase", i), ad_bad, 0);
            check($sformatf("v%0d_invariants", i), inv_bad, 0);
            check($sformatf("v%0d_busy_end", i), busy, 0);
        end
        check("data_out_hold", data_out, 8'h01);

        // start pulse to 0x30 during ADDR_WR of a read to 0x26
        run_monitor(8'h26, 8'h12, 40, 1, 5, 8'h30);
        check("ign_dv_count", dv_cnt, 1);
        check("ign_addr_phase", ad_bad, 0);
        check("ign_wr_width", wr_cnt, 8);
        check("ign_data", dat_at_dv, 8'h12);
        check("ign_invariants", inv_bad, 0);

        // reset during DATA_RD
        start = 1'b1; addr = 8'h40; ad_in = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("mid_rd_n_low", rd_n, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_rd_n", rd_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_data_valid", data_valid, 0);
        reset = 1'b0;
        begin
            int dv_seen = 0;
            int busy_seen = 0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (data_valid) dv_seen++;
                if (busy) busy_seen++;
            end
            check("mid_rst_no_dv", dv_seen, 0);
            check("mid_rst_no_busy", busy_seen, 0);
        end

        // start held high for 60 cycles
        run_monitor(8'h31, 8'h04, 56, 60, -1, 8'h00);
        check("hold_dv_first", dv_first, 25);
        check("hold_dv_second", dv_second, 51);
        check("hold_dv_count", dv_cnt, 2);
        check("hold_invariants", inv_bad, 0);
        check("hold_data", dat_at_dv, 8'h04);
        begin
            int bad = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if ((ad_oe && a_d) || (!rd_n && !wr_n) || (!rd_n && ad_oe)) bad++;
            end
            check("drain_invariants", bad, 0);
            check("drain_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
